// File: rtl/multiband_playback.sv
// Multi-band sample player: each enable strobe runs one frame reading one ROM sample per channel.
// Build option MULTIBAND_MIX_EN adds a saturated per-frame sum on mix_out_o / mix_valid_o.
module multiband_playback_ch #(
  parameter int DEPTH = 8,
  parameter int PW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          issue_i,
  input  logic          loop_mode_i,
  output logic [PW-1:0] ptr_o,
  output logic          active_o,
  output logic          done_o
);
  logic [PW-1:0] ptr_q, ptr_d;
  logic          act_q, act_d, done_q, done_d;

  always_comb begin
    ptr_d  = ptr_q;
    act_d  = act_q;
    done_d = 1'b0;
    if (frame_start_i) begin
      if (start_i) begin
        ptr_d = '0;
        act_d = 1'b1;
      end else if (stop_i) begin
        ptr_d = '0;
        act_d = 1'b0;
      end
    end else if (issue_i && act_q) begin
      if (ptr_q == PW'(DEPTH-1)) begin
        ptr_d = '0;
        if (!loop_mode_i) begin
          act_d  = 1'b0;
          done_d = 1'b1;
        end
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr_q  <= '0;
      act_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      act_q  <= act_d;
      done_q <= done_d;
    end

  assign ptr_o    = ptr_q;
  assign active_o = act_q;
  assign done_o   = done_q;
endmodule

module multiband_playback #(
  parameter int NUM_CH   = 16,
  parameter int DEPTH    = 4036,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1,
  parameter int AW       = $clog2(NUM_CH*DEPTH),
  parameter int CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_i,
  input  logic [NUM_CH-1:0] start_i,
  input  logic [NUM_CH-1:0] stop_i,
  input  logic [NUM_CH-1:0] loop_mode_i,
  output logic [AW-1:0]     mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] sample_out_o,
  output logic [CW-1:0]     sample_ch_o,
  output logic              sample_valid_o,
  output logic [NUM_CH-1:0] active_o,
  output logic [NUM_CH-1:0] done_o,
  output logic              overrun_o,
  output logic [DATA_W-1:0] mix_out_o,
  output logic              mix_valid_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;
  state_e state_q, state_d;

  logic [CW-1:0]              cnt_q, cnt_d;
  logic [DW-1:0]              dcnt_q, dcnt_d;
  logic [NUM_CH-1:0]          pend_start_q, pend_start_d, pend_stop_q, pend_stop_d;
  logic [NUM_CH-1:0]          eff_start, eff_stop, active_w;
  logic [NUM_CH-1:0][PW-1:0]  ptr_w;
  logic                       frame_start, issue, overrun_q;
  logic [AW-1:0]              mem_addr_q;
  logic [READ_LAT:0]          vld_pipe_q, act_pipe_q;
  logic [READ_LAT:0][CW-1:0]  ch_pipe_q;
  logic signed [DATA_W-1:0]   samp_d, sample_out_q;
  logic [CW-1:0]              sample_ch_q;
  logic                       sample_valid_q;

  // Requests landing on the frame-start cycle itself take effect in that frame.
  assign eff_start    = pend_start_q | start_i;
  assign eff_stop     = pend_stop_q | stop_i;
  assign pend_start_d = frame_start ? '0 : eff_start;
  assign pend_stop_d  = frame_start ? '0 : eff_stop;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dcnt_d      = dcnt_q;
    frame_start = 1'b0;
    issue       = 1'b0;
    case (state_q)
      IDLE: if (enable_i) begin
        frame_start = 1'b1;
        cnt_d       = '0;
        state_d     = ISSUE;
      end
      ISSUE: begin
        issue = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(NUM_CH-1)) begin
          cnt_d   = '0;
          dcnt_d  = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        dcnt_d = dcnt_q + 1'b1;
        if (dcnt_q == DW'(READ_LAT-1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    multiband_playback_ch #(.DEPTH(DEPTH), .PW(PW)) u_ch (
      .clk          (clk),
      .rst          (rst),
      .frame_start_i(frame_start),
      .start_i      (eff_start[g]),
      .stop_i       (eff_stop[g]),
      .issue_i      (issue && (cnt_q == CW'(g))),
      .loop_mode_i  (loop_mode_i[g]),
      .ptr_o        (ptr_w[g]),
      .active_o     (active_w[g]),
      .done_o       (done_o[g])
    );
  end

  // Tag carries the channel's pre-advance active flag so the final one-shot sample still plays.
  assign samp_d = act_pipe_q[READ_LAT] ? mem_data_i : '0;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      dcnt_q         <= '0;
      pend_start_q   <= '0;
      pend_stop_q    <= '0;
      overrun_q      <= 1'b0;
      mem_addr_q     <= '0;
      vld_pipe_q     <= '0;
      act_pipe_q     <= '0;
      ch_pipe_q      <= '0;
      sample_out_q   <= '0;
      sample_ch_q    <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dcnt_q       <= dcnt_d;
      pend_start_q <= pend_start_d;
      pend_stop_q  <= pend_stop_d;
      overrun_q    <= overrun_q | (enable_i && state_q != IDLE);
      if (issue) mem_addr_q <= AW'(cnt_q) * AW'(DEPTH) + AW'(ptr_w[cnt_q]);
      vld_pipe_q   <= {vld_pipe_q[READ_LAT-1:0], issue};
      act_pipe_q   <= {act_pipe_q[READ_LAT-1:0], active_w[cnt_q]};
      ch_pipe_q    <= {ch_pipe_q[READ_LAT-1:0], cnt_q};
      sample_valid_q <= vld_pipe_q[READ_LAT];
      if (vld_pipe_q[READ_LAT]) begin
        sample_out_q <= samp_d;
        sample_ch_q  <= ch_pipe_q[READ_LAT];
      end
    end

  assign mem_addr_o     = mem_addr_q;
  assign sample_out_o   = sample_out_q;
  assign sample_ch_o    = sample_ch_q;
  assign sample_valid_o = sample_valid_q;
  assign active_o       = active_w;
  assign overrun_o      = overrun_q;

`ifdef MULTIBAND_MIX_EN
  localparam int ACC_W = DATA_W + CW;
  localparam logic signed [ACC_W-1:0] SMAX = {{(CW+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = {{(CW+1){1'b1}}, {(DATA_W-1){1'b0}}};
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]       mix_q, mix_d;
  logic                    mixv_d, mixv_q;

  always_comb begin
    acc_d = acc_q;
    if (frame_start) acc_d = '0;
    else if (vld_pipe_q[READ_LAT]) acc_d = acc_q + ACC_W'(samp_d);
    mixv_d = sample_valid_q && (sample_ch_q == CW'(NUM_CH-1));
    mix_d  = mix_q;
    if (mixv_d) begin
      if (acc_q > SMAX)      mix_d = SMAX[DATA_W-1:0];
      else if (acc_q < SMIN) mix_d = SMIN[DATA_W-1:0];
      else                   mix_d = acc_q[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc_q  <= '0;
      mix_q  <= '0;
      mixv_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      mix_q  <= mix_d;
      mixv_q <= mixv_d;
    end

  assign mix_out_o   = mix_q;
  assign mix_valid_o = mixv_q;
`else
  assign mix_out_o   = '0;
  assign mix_valid_o = 1'b0;
`endif
endmodule

// File: tb/tb_multiband_playback.sv
// Directed bench for multiband_playback: NUM_CH=4, DEPTH=8, READ_LAT=1, ROM word = address.
module tb_multiband_playback;
  localparam int NUM_CH = 4, DEPTH = 8, DATA_W = 16, READ_LAT = 1, AW = 5, CW = 2;

  logic              clk = 1'b0;
  logic              rst, enable, rom_const;
  logic [3:0]        start, stop, loop_mode, active, done;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_data, sample_out, mix_out;
  logic [CW-1:0]     sample_ch;
  logic              sample_valid, overrun, mix_valid;

  int cmp = 0, err = 0;
  logic [15:0] fr_samp [4];
  int          fr_n, fr_first, fr_last, fr_mix_idx;
  logic        fr_order_ok;
  logic [3:0]  fr_done;
  logic [15:0] fr_mix_val;

  always #5 clk = ~clk;
  always @(posedge clk) mem_data <= rom_const ? 16'h7000 : 16'(mem_addr);

  multiband_playback #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .DATA_W(DATA_W), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .rst(rst), .enable_i(enable), .start_i(start), .stop_i(stop),
    .loop_mode_i(loop_mode), .mem_addr_o(mem_addr), .mem_data_i(mem_data),
    .sample_out_o(sample_out), .sample_ch_o(sample_ch), .sample_valid_o(sample_valid),
    .active_o(active), .done_o(done), .overrun_o(overrun),
    .mix_out_o(mix_out), .mix_valid_o(mix_valid)
  );

  task automatic pulse_req(input logic [3:0] st, input logic [3:0] sp);
    @(negedge clk); start = st; stop = sp;
    @(negedge clk); start = '0; stop = '0;
  endtask

  // One enable strobe, then a 12-cycle capture window; at window index k drive st/sp/en2.
  task automatic run_frame(input int k, input logic [3:0] st, input logic [3:0] sp, input logic en2);
    fr_n = 0; fr_first = -1; fr_last = -1; fr_mix_idx = -1; fr_mix_val = '0;
    fr_order_ok = 1'b1; fr_done = '0;
    for (int c = 0; c < 4; c++) fr_samp[c] = 16'hDEAD;
    @(negedge clk); enable = 1'b1;
    @(negedge clk); enable = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (sample_valid) begin
        if (fr_n < 4) begin
          if (sample_ch !== 2'(fr_n)) fr_order_ok = 1'b0;
          else fr_samp[fr_n] = sample_out;
        end
        if (fr_first < 0) fr_first = i;
        if (sample_ch === 2'd3) fr_last = i;
        fr_n++;
      end
      fr_done = fr_done | done;
      if (mix_valid) begin fr_mix_idx = i; fr_mix_val = mix_out; end
      if (i == k) begin start = st; stop = sp; enable = en2; end
      else begin start = '0; stop = '0; enable = 1'b0; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    cmp++; if ({sample_valid, sample_out, sample_ch} !== 19'd0) begin err++;
      $display("FAIL reset_sample: got %0h expected 0", {sample_valid, sample_out, sample_ch}); end
    cmp++; if ({active, done, overrun} !== 9'd0) begin err++;
      $display("FAIL reset_status: got %0h expected 0", {active, done, overrun}); end
    cmp++; if (mem_addr !== 5'd0) begin err++;
      $display("FAIL reset_addr: got %0h expected 0", mem_addr); end
    cmp++; if ({mix_out, mix_valid} !== 17'd0) begin err++;
      $display("FAIL reset_mix: got %0h expected 0", {mix_out, mix_valid}); end
  endtask

  task automatic test_oneshot();
    loop_mode = 4'b0000;
    pulse_req(4'b0100, 4'b0000);
    for (int f = 0; f < 9; f++) begin
      logic [15:0] exp2;
      logic [3:0]  expd;
      run_frame(-1, '0, '0, 1'b0);
      exp2 = (f < 8) ? 16'(16 + f) : 16'd0;
      expd = (f == 7) ? 4'b0100 : 4'b0000;
      cmp++; if (fr_samp[2] !== exp2) begin err++;
        $display("FAIL oneshot_ch2 f%0d: got %0d expected %0d", f, fr_samp[2], exp2); end
      cmp++; if ({fr_samp[0], fr_samp[1], fr_samp[3]} !== 48'd0) begin err++;
        $display("FAIL oneshot_others f%0d: got %0h %0h %0h expected 0", f, fr_samp[0], fr_samp[1], fr_samp[3]); end
      cmp++; if (fr_done !== expd) begin err++;
        $display("FAIL oneshot_done f%0d: got %b expected %b", f, fr_done, expd); end
      cmp++; if (active[2] !== 1'(f < 7)) begin err++;
        $display("FAIL oneshot_active f%0d: got %b expected %b", f, active[2], 1'(f < 7)); end
      cmp++; if (fr_n !== 4 || !fr_order_ok || fr_last - fr_first !== 3) begin err++;
        $display("FAIL oneshot_frame f%0d: got n=%0d order=%b span=%0d expected 4/1/3", f, fr_n, fr_order_ok, fr_last - fr_first); end
      if (f == 0) begin
        cmp++; if (fr_first !== 3) begin err++;
          $display("FAIL latency: got first valid at %0d expected 3", fr_first); end
      end
    end
    cmp++; if (overrun !== 1'b0) begin err++;
      $display("FAIL oneshot_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_loop();
    loop_mode = 4'b0001;
    pulse_req(4'b0001, 4'b0000);
    for (int f = 0; f < 10; f++) begin
      run_frame(-1, '0, '0, 1'b0);
      cmp++; if (fr_samp[0] !== 16'(f % 8)) begin err++;
        $display("FAIL loop_ch0 f%0d: got %0d expected %0d", f, fr_samp[0], f % 8); end
      cmp++; if (active[0] !== 1'b1 || fr_done !== 4'b0) begin err++;
        $display("FAIL loop_state f%0d: got active=%b done=%b expected 1/0000", f, active[0], fr_done); end
    end
    pulse_req(4'b0000, 4'b0001);
    run_frame(-1, '0, '0, 1'b0);
    cmp++; if (fr_samp[0] !== 16'd0 || active[0] !== 1'b0 || fr_done !== 4'b0) begin err++;
      $display("FAIL stop_ch0: got samp=%0d active=%b done=%b expected 0/0/0000", fr_samp[0], active[0], fr_done); end
  endtask

  task automatic test_start_stop();
    run_frame(1, 4'b0010, 4'b0010, 1'b0);
    cmp++; if (fr_samp[1] !== 16'd0 || active[1] !== 1'b0) begin err++;
      $display("FAIL startstop_now: got samp=%0d active=%b expected 0/0", fr_samp[1], active[1]); end
    run_frame(-1, '0, '0, 1'b0);
    cmp++; if (fr_samp[1] !== 16'd8 || active[1] !== 1'b1) begin err++;
      $display("FAIL startstop_next: got samp=%0d active=%b expected 8/1", fr_samp[1], active[1]); end
  endtask

  task automatic test_overrun();
    run_frame(1, '0, '0, 1'b1);
    cmp++; if (overrun !== 1'b1) begin err++;
      $display("FAIL overrun_set: got %b expected 1", overrun); end
    cmp++; if (fr_n !== 4 || !fr_order_ok || fr_samp[1] !== 16'd9) begin err++;
      $display("FAIL overrun_frame: got n=%0d order=%b ch1=%0d expected 4/1/9", fr_n, fr_order_ok, fr_samp[1]); end
    run_frame(-1, '0, '0, 1'b0);
    cmp++; if (overrun !== 1'b1 || fr_samp[1] !== 16'd10) begin err++;
      $display("FAIL overrun_sticky: got ovr=%b ch1=%0d expected 1/10", overrun, fr_samp[1]); end
  endtask

  task automatic test_rst_mid();
    logic seen;
    loop_mode = 4'b0000;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    cmp++; if (overrun !== 1'b0 || active !== 4'b0) begin err++;
      $display("FAIL rst_clear: got ovr=%b active=%b expected 0/0000", overrun, active); end
    pulse_req(4'b1000, 4'b0000);
    for (int f = 0; f < 5; f++) begin
      run_frame(-1, '0, '0, 1'b0);
      cmp++; if (fr_samp[3] !== 16'(24 + f)) begin err++;
        $display("FAIL rst_pre_ch3 f%0d: got %0d expected %0d", f, fr_samp[3], 24 + f); end
    end
    @(negedge clk); enable = 1'b1;
    @(negedge clk); enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    cmp++; if ({sample_valid, sample_out, mem_addr, active, done} !== 30'd0) begin err++;
      $display("FAIL rst_mid_outputs: got %0h expected 0", {sample_valid, sample_out, mem_addr, active, done}); end
    seen = 1'b0;
    repeat (3) begin @(negedge clk); seen = seen | sample_valid; end
    rst = 1'b0;
    repeat (8) begin @(negedge clk); seen = seen | sample_valid; end
    cmp++; if (seen !== 1'b0 || active !== 4'b0) begin err++;
      $display("FAIL rst_mid_quiet: got valid_seen=%b active=%b expected 0/0000", seen, active); end
    pulse_req(4'b1000, 4'b0000);
    run_frame(-1, '0, '0, 1'b0);
    cmp++; if (fr_samp[3] !== 16'd24 || fr_n !== 4) begin err++;
      $display("FAIL rst_restart: got ch3=%0d n=%0d expected 24/4", fr_samp[3], fr_n); end
  endtask

  task automatic test_mix();
`ifdef MULTIBAND_MIX_EN
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    rom_const = 1'b1;
    pulse_req(4'b1111, 4'b0000);
    run_frame(-1, '0, '0, 1'b0);
    cmp++; if (fr_mix_val !== 16'h7FFF) begin err++;
      $display("FAIL mix_sat: got %0h expected 7fff", fr_mix_val); end
    cmp++; if (fr_last < 0 || fr_mix_idx !== fr_last + 1) begin err++;
      $display("FAIL mix_timing: got idx %0d expected %0d", fr_mix_idx, fr_last + 1); end
    rom_const = 1'b0;
`else
    pulse_req(4'b1111, 4'b0000);
    run_frame(-1, '0, '0, 1'b0);
    cmp++; if (fr_mix_idx !== -1 || mix_out !== 16'd0 || mix_valid !== 1'b0) begin err++;
      $display("FAIL mix_off: got idx=%0d out=%0h vld=%b expected -1/0/0", fr_mix_idx, mix_out, mix_valid); end
    cmp++; if (fr_samp[0] !== 16'd0 || fr_samp[2] !== 16'd16 || fr_n !== 4) begin err++;
      $display("FAIL all_start: got ch0=%0d ch2=%0d n=%0d expected 0/16/4", fr_samp[0], fr_samp[2], fr_n); end
`endif
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; start = '0; stop = '0; loop_mode = '0; rom_const = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_oneshot();
    test_loop();
    test_start_stop();
    test_overrun();
    test_rst_mid();
    test_mix();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule

// File: doc/multiband_playback.md
Name: multiband_playback

Overview:
- Parametrised successor to the single-band sample player. Time-multiplexes NUM_CH bands from one shared sample ROM.
- On each 44 kHz enable strobe, runs one frame: reads one sample per channel and emits the samples in channel order.
- Each channel has independent start/stop, loop or one-shot mode, and a done pulse.
- Sits between the band ROM (BRAM) and the equaliser/mixer stage.

Parameters:
NUM_CH, 16, number of bands/channels
DEPTH, 4036, samples per channel region
DATA_W, 16, signed sample width
READ_LAT, 1, ROM read latency in clk cycles (1..4)
AW, $clog2(NUM_CH*DEPTH), ROM address width (derived)

Ports:
clk  in  1  system clock (4.4 MHz)
rst  in  1  asynchronous, active-high reset
enable  in  1  sample-rate strobe, one clk wide
start  in  NUM_CH  per-channel start request pulse
stop  in  NUM_CH  per-channel stop request pulse
loop_mode  in  NUM_CH  1 = wrap at end of region, 0 = one-shot
mem_addr  out  AW  ROM address, ch*DEPTH + ptr[ch]
mem_data  in  DATA_W  ROM read data, valid READ_LAT cycles after mem_addr
sample_out  out  DATA_W  signed sample of channel sample_ch
sample_ch  out  $clog2(NUM_CH)  channel index of sample_out
sample_valid  out  1  one-cycle qualifier for sample_out/sample_ch
active  out  NUM_CH  channel currently playing
done  out  NUM_CH  one-cycle pulse when a one-shot channel finishes
overrun  out  1  sticky: enable arrived while a frame was in progress
mix_out  out  DATA_W  saturated sum of frame (MIX_EN only)
mix_valid  out  1  mix_out qualifier (MIX_EN only)

Behaviour:
- Reset values: all ptr = 0, active = 0, pending start/stop = 0, FSM = IDLE. All outputs are 0, including mem_addr, overrun, mix_out and mix_valid.
- Request latching: start/stop pulses are latched into pending bits on any cycle. They are applied at the next frame start. If both are pending for a channel, start wins. Start: ptr = 0, active = 1 (also restarts a channel that is already active). Stop: active = 0, ptr = 0, no done pulse.
- FSM states: IDLE -> ISSUE -> DRAIN -> IDLE.
- IDLE + enable: apply pending bits, clear them, set issue counter c = 0, go to ISSUE.
- ISSUE: drive mem_addr = c*DEPTH + ptr[c] for one cycle each, c = 0..NUM_CH-1. The channel tag and active flag are pipelined READ_LAT deep. After c = NUM_CH-1, go to DRAIN.
- DRAIN: wait until the last tag leaves the pipeline, then go to IDLE.
- Frame length is NUM_CH + READ_LAT cycles and must be less than the enable period (100 clk).
- Output: sample_valid = 1 exactly READ_LAT+1 cycles after each address issue, i.e. one registered output stage. sample_out = mem_data if the tagged channel was active, else 0. Exactly NUM_CH valid pulses per frame, channels in ascending order, back-to-back.
- Pointer advance: happens at the issue cycle of an active channel.
  - ptr < DEPTH-1: ptr + 1.
  - ptr == DEPTH-1 and loop_mode = 1: ptr = 0, channel stays active.
  - ptr == DEPTH-1 and loop_mode = 0: ptr = 0, active = 0, done pulses in the same cycle.
  - Inactive channel: ptr holds.
- loop_mode is sampled live at the wrap cycle.
- enable outside IDLE: the strobe is ignored and overrun is set sticky (cleared only by rst).
- Start/stop arriving mid-frame is latched and applied at the next frame, never mid-frame.
- rst mid-frame: immediate return to reset state. No further sample_valid pulses; in-flight pipeline tags are discarded.
- mem_addr holds its last value outside ISSUE.

Optional Feature:
- Macro: MULTIBAND_MIX_EN.
- Defined: an accumulator of width DATA_W + $clog2(NUM_CH) sums sample_out across the frame.
  - The accumulator clears at frame start.
  - One cycle after the last sample_valid of the frame: mix_out = accumulator saturated to the signed DATA_W range, and mix_valid pulses for 1 cycle.
- Undefined: no accumulator is built; mix_out = 0 and mix_valid = 0 permanently.

Test Plan:
- Settings for this test: NUM_CH=4, DEPTH=8, READ_LAT=1, ROM word = address. Start ch2 with loop_mode=0, then 9 enables -> ch2 emits 16, 17 ... 23; 8th frame pulses done[2] with active[2]=0; 9th frame ch2 sample = 0; the other channels emit 0 every frame.
- Same settings, start ch0 with loop_mode=1, 10 enables -> samples 0..7, 0, 1; active[0] stays 1; done never pulses.
- Start and stop pulsed together on ch1 mid-frame -> no change in the current frame; at the next frame ch1 is active from ptr 0 (sample 8).
- enable re-asserted 2 cycles after a frame starts -> strobe ignored, overrun = 1 and stays 1; the current frame still emits exactly 4 valid pulses, channels 0..3 in order.
- rst asserted during ISSUE with ch3 playing at ptr 5 -> outputs 0 immediately, no valid pulses; after release, active = 0 and the next start[3] plays from 24.
- MULTIBAND_MIX_EN defined, DATA_W=16, ROM words 0x7000 on all active channels, all 4 channels started -> mix_out = 0x7FFF (saturated) with mix_valid one cycle after the ch3 sample.
